aes_job_arbiter: RTL and testbench

// - Shares one iterative AES core (load/enc/din/key -> ready/dout handshake) among NUM_REQ requesters.
// - Round-robin selection; operands are latched and held stable for the whole job.
// - A job is issued as a single-cycle core_load; each result is returned with the requester's one-hot id.
// - A watchdog flushes a hung core.
// - Sits between the requesting engines and the shared AES core in the cipher subsystem.

---
 rtl/aes_arb_pkg.sv | 32 +++
 rtl/aes_job_arbiter_if.sv | 34 +++
 rtl/aes_job_arbiter_rr.sv | 35 +++
 rtl/aes_job_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES job arbiter: datapath widths, FSM state
// encoding and a small index helper.
package aes_arb_pkg;

    localparam int AES_W = 128;
    localparam int WD_W  = 12;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP
    } arb_state_e;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Handshake bundle between the job arbiter (master) and the shared
// iterative AES core (slave).
interface aes_job_arbiter_if;
    import aes_arb_pkg::*;

    logic             core_load;
    logic             core_enc;
    logic [AES_W-1:0] core_din;
    logic [AES_W-1:0] core_key;
    logic             core_ready;
    logic [AES_W-1:0] core_dout;
    logic             core_flush_n;

    modport master (
        output core_load,
        output core_enc,
        output core_din,
        output core_key,
        output core_flush_n,
        input  core_ready,
        input  core_dout
    );

    modport slave (
        input  core_load,
        input  core_enc,
        input  core_din,
        input  core_key,
        input  core_flush_n,
        output core_ready,
        output core_dout
    );

endinterface

// File: rtl/aes_job_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// wrapping, reported both one-hot and as a binary index.
module rr_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan the ring starting at rr_ptr; the first hit locks the result.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s        = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            hit_s         = req[cand_s] & ~grant_vld;
            grant[cand_s] = grant[cand_s] | hit_s;
            grant_idx     = hit_s ? cand_s : grant_idx;
            grant_vld     = grant_vld | hit_s;
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Round-robin sharing of one iterative AES core among NUM_REQ requesters,
// with operand latching, per-job watchdog and one-hot response routing.
module aes_job_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 4095,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_enc,
    input  logic [NUM_REQ*AES_W-1:0] req_din,
    input  logic [NUM_REQ*AES_W-1:0] req_key,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [AES_W-1:0]         rsp_dout,
    output logic                     rsp_err,
    output logic                     busy,
    aes_job_arbiter_if.master        core
);

    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    arb_state_e         state_r;
    arb_state_e         state_s;
    logic               pick_s;
    logic               done_ok_s;
    logic               timeout_s;

    logic [NUM_REQ-1:0] arb_grant_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_vld_s;
    logic               sel_enc_s;
    logic [AES_W-1:0]   sel_din_s;
    logic [AES_W-1:0]   sel_key_s;

    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   owner_r;
    logic [NUM_REQ-1:0] owner_oh_r;
    logic [WD_W-1:0]    wd_cnt_r;
    logic               enc_r;
    logic [AES_W-1:0]   din_r;
    logic [AES_W-1:0]   key_r;
    logic [NUM_REQ-1:0] grant_r;
    logic               load_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [AES_W-1:0]   rsp_dout_r;
    logic               rsp_err_r;
    logic               busy_r;
    logic               flush_n_r;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .grant_vld (arb_vld_s)
    );

    // One-hot operand mux driven by the arbiter grant.
    always_comb begin
        sel_enc_s = 1'b0;
        sel_din_s = '0;
        sel_key_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_enc_s = sel_enc_s | (arb_grant_s[i] & req_enc[i]);
            sel_din_s = sel_din_s | ({AES_W{arb_grant_s[i]}} & req_din[i*AES_W +: AES_W]);
            sel_key_s = sel_key_s | ({AES_W{arb_grant_s[i]}} & req_key[i*AES_W +: AES_W]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; ready has priority over the watchdog in WAIT.
    always_comb begin
        state_s   = state_r;
        pick_s    = 1'b0;
        done_ok_s = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_vld_s) begin
                    pick_s  = 1'b1;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (core.core_ready) begin
                    done_ok_s = 1'b1;
                    state_s   = ST_RESP;
                end else if (wd_cnt_r == WD_MAX) begin
                    timeout_s = 1'b1;
                    state_s   = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Operand latch, watchdog, round-robin pointer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r    <= '0;
            owner_r     <= '0;
            owner_oh_r  <= '0;
            wd_cnt_r    <= '0;
            enc_r       <= 1'b0;
            din_r       <= '0;
            key_r       <= '0;
            grant_r     <= '0;
            load_r      <= 1'b0;
            rsp_valid_r <= '0;
            rsp_dout_r  <= '0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            flush_n_r   <= 1'b1;
        end else begin
            if (pick_s) begin
                owner_r    <= arb_idx_s;
                owner_oh_r <= arb_grant_s;
                enc_r      <= sel_enc_s;
                din_r      <= sel_din_s;
                key_r      <= sel_key_s;
            end

            if (state_r == ST_ISSUE) begin
                wd_cnt_r <= '0;
            end else if (state_r == ST_WAIT) begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1);
            end

            if (done_ok_s) begin
                rsp_dout_r <= core.core_dout;
                rsp_err_r  <= 1'b0;
            end else if (timeout_s) begin
                rsp_dout_r <= '0;
                rsp_err_r  <= 1'b1;
            end

            // The owner just served drops to lowest priority for the next pick.
            if (state_r == ST_RESP) begin
                rr_ptr_r <= IDX_W'(wrap_inc(int'(owner_r), NUM_REQ));
            end

            grant_r     <= pick_s ? arb_grant_s : '0;
            load_r      <= pick_s;
            rsp_valid_r <= (state_s == ST_RESP) ? owner_oh_r : '0;
            busy_r      <= (state_s != ST_IDLE);
            flush_n_r   <= ~timeout_s;
        end
    end

    assign req_grant         = grant_r;
    assign rsp_valid         = rsp_valid_r;
    assign rsp_dout          = rsp_dout_r;
    assign rsp_err           = rsp_err_r;
    assign busy              = busy_r;
    assign core.core_load    = load_r;
    assign core.core_enc     = enc_r;
    assign core.core_din     = din_r;
    assign core.core_key     = key_r;
    assign core.core_flush_n = flush_n_r;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Self-checking bench for aes_job_arbiter: the bench acts as requesters and
// as a stub AES core, and predicts every pick, result and timing itself.
`timescale 1ns/1ps
module tb_aes_job_arbiter;
    import aes_arb_pkg::*;

    localparam int N  = 4;
    localparam int IW = $clog2(N);
    localparam int TO = 4095;
    localparam logic [127:0] KAT_DIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_enc;
    logic [N*128-1:0] req_din;
    logic [N*128-1:0] req_key;
    logic [N-1:0]     req_grant;
    logic [N-1:0]     rsp_valid;
    logic [127:0]     rsp_dout;
    logic             rsp_err;
    logic             busy;
    logic [127:0]     din_a [N];
    logic [127:0]     key_a [N];

    aes_job_arbiter_if core_if ();

    aes_job_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_enc   (req_enc),
        .req_din   (req_din),
        .req_key   (req_key),
        .req_grant (req_grant),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .core      (core_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_din = '0;
        req_key = '0;
        for (int i = 0; i < N; i++) begin
            req_din[i*128 +: 128] = din_a[i];
            req_key[i*128 +: 128] = key_a[i];
        end
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    int           m_ptr   = 0;
    logic [127:0] last_dout = '0;
    logic         last_err  = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference pick: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[IW'((ptr + k) % N)]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Stand-in cipher for the stub core; only needs to be operand dependent.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k, input logic e);
        return e ? (d ^ {k[63:0], k[127:64]}) : (d + k);
    endfunction

    task automatic set_req(input int r);
        req_valid[IW'(r)] = 1'b1;
        req_enc[IW'(r)]   = 1'($urandom);
        din_a[IW'(r)]     = {$urandom, $urandom, $urandom, $urandom};
        key_a[IW'(r)]     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_grant"},   req_grant, '0);
        check_val({tag, "_rspv"},    rsp_valid, '0);
        check_val({tag, "_dout"},    rsp_dout, '0);
        check_val({tag, "_err"},     rsp_err, '0);
        check_val({tag, "_busy"},    busy, '0);
        check_val({tag, "_load"},    core_if.core_load, '0);
        check_val({tag, "_enc"},     core_if.core_enc, '0);
        check_val({tag, "_din"},     core_if.core_din, '0);
        check_val({tag, "_key"},     core_if.core_key, '0);
        check_val({tag, "_flush_n"}, core_if.core_flush_n, 128'd1);
    endtask

    task automatic check_wait(input logic [127:0] d, input logic [127:0] k, input logic e);
        check_val("wait_load",    core_if.core_load, '0);
        check_val("wait_busy",    busy, 128'd1);
        check_val("wait_grant",   req_grant, '0);
        check_val("wait_rspv",    rsp_valid, '0);
        check_val("wait_flush_n", core_if.core_flush_n, 128'd1);
        check_val("wait_din",     core_if.core_din, d);
        check_val("wait_key",     core_if.core_key, k);
        check_val("wait_enc",     core_if.core_enc, e);
    endtask

    // Runs one job from the IDLE cycle in which requests are presented and
    // returns at the negedge of the following IDLE cycle.
    task automatic do_job(input int lat, input bit hang, input bit kat, input bit inject, output int own);
        logic [127:0] d;
        logic [127:0] k;
        logic [127:0] dv;
        logic         e;
        logic [N-1:0] oh;
        int           r;
        own = model_pick(req_valid, m_ptr);
        d   = din_a[IW'(own)];
        k   = key_a[IW'(own)];
        e   = req_enc[IW'(own)];
        oh  = '0;
        oh[IW'(own)] = 1'b1;
        @(negedge clk);
        check_val("issue_grant", req_grant, oh);
        check_val("issue_load",  core_if.core_load, 128'd1);
        check_val("issue_busy",  busy, 128'd1);
        check_val("issue_din",   core_if.core_din, d);
        check_val("issue_key",   core_if.core_key, k);
        check_val("issue_enc",   core_if.core_enc, e);
        req_valid[IW'(own)] = 1'b0;
        din_a[IW'(own)]     = ~d;
        key_a[IW'(own)]     = ~k;
        if (hang) begin
            for (int c = 0; c < TO; c++) begin
                @(negedge clk);
                check_wait(d, k, e);
            end
            @(negedge clk);
            check_val("to_flush_n", core_if.core_flush_n, '0);
            check_val("to_rspv",    rsp_valid, oh);
            check_val("to_err",     rsp_err, 128'd1);
            check_val("to_dout",    rsp_dout, '0);
            check_val("to_busy",    busy, 128'd1);
            last_dout = '0;
            last_err  = 1'b1;
        end else begin
            for (int c = 1; c < lat; c++) begin
                @(negedge clk);
                check_wait(d, k, e);
                if (inject && $urandom_range(0, 7) == 0) begin
                    r = $urandom_range(0, N - 1);
                    if (!req_valid[IW'(r)]) set_req(r);
                end
            end
            @(negedge clk);
            check_wait(d, k, e);
            dv = kat ? KAT_OUT : core_fn(d, k, e);
            core_if.core_ready = 1'b1;
            core_if.core_dout  = dv;
            @(negedge clk);
            core_if.core_ready = 1'b0;
            core_if.core_dout  = {$urandom, $urandom, $urandom, $urandom};
            check_val("rsp_valid",   rsp_valid, oh);
            check_val("rsp_err",     rsp_err, '0);
            check_val("rsp_dout",    rsp_dout, dv);
            check_val("rsp_flush_n", core_if.core_flush_n, 128'd1);
            check_val("rsp_busy",    busy, 128'd1);
            last_dout = dv;
            last_err  = 1'b0;
        end
        m_ptr = (own + 1) % N;
        @(negedge clk);
        check_val("idle_busy",    busy, '0);
        check_val("idle_rspv",    rsp_valid, '0);
        check_val("idle_grant",   req_grant, '0);
        check_val("idle_dout",    rsp_dout, last_dout);
        check_val("idle_err",     rsp_err, last_err);
        check_val("idle_flush_n", core_if.core_flush_n, 128'd1);
    endtask

    task automatic idle_ready_pulse();
        core_if.core_ready = 1'b1;
        core_if.core_dout  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        core_if.core_ready = 1'b0;
        check_val("idlerdy_busy", busy, '0);
        check_val("idlerdy_rspv", rsp_valid, '0);
        check_val("idlerdy_dout", rsp_dout, last_dout);
        check_val("idlerdy_load", core_if.core_load, '0);
        @(negedge clk);
        check_val("idlerdy_busy2", busy, '0);
        check_val("idlerdy_rspv2", rsp_valid, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int own;
        int first;
        req_valid          = '0;
        req_enc            = '0;
        for (int i = 0; i < N; i++) begin
            din_a[i] = '0;
            key_a[i] = '0;
        end
        core_if.core_ready = 1'b0;
        core_if.core_dout  = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Known-answer job on requester 0 with a 200-cycle core.
        req_valid    = 4'b0001;
        req_enc[0]   = 1'b1;
        din_a[0]     = KAT_DIN;
        key_a[0]     = KAT_KEY;
        do_job(200, 1'b0, 1'b1, 1'b0, own);

        idle_ready_pulse();

        // Serve 1 alone, then {0,1} with the pointer at 2 must wrap to 0.
        set_req(1);
        do_job(5, 1'b0, 1'b0, 1'b0, own);
        set_req(0);
        set_req(1);
        do_job(3, 1'b0, 1'b0, 1'b0, own);
        do_job(4, 1'b0, 1'b0, 1'b0, own);

        // Abort a job in WAIT with the pointer away from 0.
        for (int i = 0; i < N; i++) set_req(i);
        first = model_pick(req_valid, m_ptr);
        @(negedge clk);
        check_val("abort_grant", req_grant, N'(1) << first);
        req_valid[IW'(first)] = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        reset     = 1'b1;
        m_ptr     = 0;
        last_dout = '0;
        last_err  = 1'b0;
        set_req(first);

        // All four requesting continuously: expect 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            do_job($urandom_range(1, 10), 1'b0, 1'b0, 1'b0, own);
            if (j < 4) set_req(own);
        end

        // Hung core, then the next requester, then ready on the last WAIT cycle.
        do_job(0, 1'b1, 1'b0, 1'b0, own);
        do_job($urandom_range(1, 10), 1'b0, 1'b0, 1'b0, own);
        do_job(TO, 1'b0, 1'b0, 1'b0, own);

        idle_ready_pulse();

        for (int j = 0; j < 40; j++) begin
            if (req_valid == '0) begin
                if ($urandom_range(0, 3) == 0) idle_ready_pulse();
                set_req($urandom_range(0, N - 1));
            end
            if ($urandom_range(0, 1) == 1) begin
                first = $urandom_range(0, N - 1);
                if (!req_valid[IW'(first)]) set_req(first);
            end
            do_job($urandom_range(1, 24), 1'b0, 1'b0, 1'b1, own);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
